// File: rtl/calcore_pkg.sv
// calcore_pkg: shared types and encodings for the CalCore decode stage.
//   op_t        - decoded operation class carried on out_op
//   OPC_*       - major opcodes (instr[6:0])
//   FUNCT3_*    - funct3 selectors for the SET opcode
//   dec_entry_t - one decoded instruction as stored in the skid FIFO
package calcore_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SET_H   = 3'd1,
    OP_SET_W   = 3'd2,
    OP_BMI     = 3'd3,
    OP_BMR     = 3'd4,
    OP_ILLEGAL = 3'd7
  } op_t;

  localparam logic [6:0] OPC_SET  = 7'b0001011;
  localparam logic [6:0] OPC_BMI  = 7'b0001101;
  localparam logic [6:0] OPC_BMR  = 7'b0001110;

  localparam logic [2:0] FUNCT3_H = 3'b000;
  localparam logic [2:0] FUNCT3_W = 3'b001;

  // Profile field is sized for the largest supported profile count (32);
  // the top level truncates it to PROF_W on the way out.
  localparam int PROF_W_MAX = 5;

  typedef struct packed {
    op_t                   op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [11:0]           imm;
    logic                  gender;
    logic [5:0]            age;
    logic [PROF_W_MAX-1:0] profile;
    logic                  err_illegal;
    logic                  err_incomplete;
  } dec_entry_t;

  // True for the ops that name a profile through rs1.
  function automatic logic op_uses_profile(input op_t op);
    return (op == OP_SET_H) || (op == OP_SET_W) ||
           (op == OP_BMI)   || (op == OP_BMR);
  endfunction

endpackage

// File: rtl/calcore_dec_comb.sv
// calcore_dec_comb: purely combinational CalCore instruction decoder.
// Ports:
//   i_instr  - raw 32-bit instruction
//   i_h_set  - per-profile "height set" flags (state before this cycle)
//   i_w_set  - per-profile "weight set" flags (state before this cycle)
//   o_entry  - decoded fields plus illegal/incomplete error bits
module calcore_dec_comb
  import calcore_pkg::*;
#(
  parameter int NUM_PROFILES = 4
) (
  input  logic [31:0]             i_instr,
  input  logic [NUM_PROFILES-1:0] i_h_set,
  input  logic [NUM_PROFILES-1:0] i_w_set,
  output dec_entry_t              o_entry
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic       w_prof_ok;
  logic       w_h;
  logic       w_w;

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_rs1     = i_instr[19:15];
  assign w_prof_ok = (32'(w_rs1) < NUM_PROFILES);

  // Flag lookup by comparison rather than indexing so an out-of-range rs1
  // simply reads as "not set" for any NUM_PROFILES.
  always_comb begin
    w_h = 1'b0;
    w_w = 1'b0;
    for (int i = 0; i < NUM_PROFILES; i++) begin
      if (w_rs1 == 5'(i)) begin
        w_h = i_h_set[i];
        w_w = i_w_set[i];
      end
    end
  end

  always_comb begin
    o_entry         = '0;
    o_entry.rd      = i_instr[11:7];
    o_entry.rs1     = w_rs1;
    o_entry.rs2     = i_instr[24:20];
    o_entry.profile = w_rs1;

    case (w_opcode)
      OPC_SET: begin
        if (w_funct3 == FUNCT3_H)      o_entry.op = OP_SET_H;
        else if (w_funct3 == FUNCT3_W) o_entry.op = OP_SET_W;
        else                           o_entry.op = OP_ILLEGAL;
      end
      OPC_BMI: o_entry.op = OP_BMI;
      OPC_BMR: o_entry.op = OP_BMR;
      default: o_entry.op = (i_instr == 32'd0) ? OP_NOP : OP_ILLEGAL;
    endcase

    if ((o_entry.op == OP_SET_H) || (o_entry.op == OP_SET_W))
      o_entry.imm = i_instr[31:20];

    if (o_entry.op == OP_BMR) begin
      o_entry.gender = i_instr[31];
      o_entry.age    = i_instr[30:25];
    end

    // Bad profile index keeps the op but marks the entry illegal.
    o_entry.err_illegal = (o_entry.op == OP_ILLEGAL) ||
                          (op_uses_profile(o_entry.op) && !w_prof_ok);

    // Incomplete only makes sense for a profile that exists.
    o_entry.err_incomplete = ((o_entry.op == OP_BMI) || (o_entry.op == OP_BMR)) &&
                             w_prof_ok && !(w_h && w_w);
  end

endmodule

// File: rtl/calcore_decode_stage.sv
// calcore_decode_stage: registered CalCore decode stage between fetch and
// the BMI/BMR execute units. Decodes one instruction per handshake, tracks
// per-profile height/weight flags and buffers results in a 2-entry FIFO.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - empties the FIFO and clears all profile flags
//   in_valid/in_ready   - instruction handshake (in_ready registered)
//   in_instr            - raw 32-bit instruction
//   out_valid/out_ready - decoded entry handshake
//   out_op..out_profile - decoded fields of the FIFO head (0 when empty)
//   out_err_illegal     - bad encoding or profile index
//   out_err_incomplete  - calc issued before height and weight were both set
//   prof_h_set/prof_w_set - per-profile flag vectors
module calcore_decode_stage
  import calcore_pkg::*;
#(
  parameter  int NUM_PROFILES = 4,
  localparam int PROF_W       = $clog2(NUM_PROFILES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_op,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [11:0]             out_imm,
  output logic                    out_gender,
  output logic [5:0]              out_age,
  output logic [PROF_W-1:0]       out_profile,
  output logic                    out_err_illegal,
  output logic                    out_err_incomplete,
  output logic [NUM_PROFILES-1:0] prof_h_set,
  output logic [NUM_PROFILES-1:0] prof_w_set
);

  dec_entry_t              w_dec;
  dec_entry_t              w_head;
  dec_entry_t              w_out;
  dec_entry_t              r_mem [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [1:0]              w_count_nxt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [NUM_PROFILES-1:0] r_h_set;
  logic [NUM_PROFILES-1:0] r_w_set;
  logic                    w_push;
  logic                    w_pop;

  calcore_dec_comb #(
    .NUM_PROFILES (NUM_PROFILES)
  ) u_dec (
    .i_instr (in_instr),
    .i_h_set (r_h_set),
    .i_w_set (r_w_set),
    .o_entry (w_dec)
  );

  // Flush wins over a same-cycle handshake: the offered instruction is lost.
  assign w_push      = in_valid && r_in_ready && !flush;
  assign w_pop       = r_out_valid && out_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Control: FIFO pointers, occupancy, handshake flags and the scoreboard.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_h_set     <= '0;
      r_w_set     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      if (w_push && !w_dec.err_illegal) begin
        for (int i = 0; i < NUM_PROFILES; i++) begin
          if (w_dec.profile == 5'(i)) begin
            if (w_dec.op == OP_SET_H) r_h_set[i] <= 1'b1;
            if (w_dec.op == OP_SET_W) r_w_set[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Data: FIFO storage, written only on an accepted instruction.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // Head of FIFO; forced to zero when empty so reset/flush read back clean.
  assign w_head = r_mem[r_rd_ptr];
  assign w_out  = r_out_valid ? w_head : '0;

  assign in_ready           = r_in_ready;
  assign out_valid          = r_out_valid;
  assign out_op             = w_out.op;
  assign out_rd             = w_out.rd;
  assign out_rs1            = w_out.rs1;
  assign out_rs2            = w_out.rs2;
  assign out_imm            = w_out.imm;
  assign out_gender         = w_out.gender;
  assign out_age            = w_out.age;
  assign out_profile        = PROF_W'(w_out.profile);
  assign out_err_illegal    = w_out.err_illegal;
  assign out_err_incomplete = w_out.err_incomplete;
  assign prof_h_set         = r_h_set;
  assign prof_w_set         = r_w_set;

endmodule

// File: tb/tb_calcore_decode_stage.sv
// Directed bench for calcore_decode_stage with hand-computed expectations.
module tb_calcore_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [11:0] out_imm;
  logic        out_gender;
  logic [5:0]  out_age;
  logic [1:0]  out_profile;
  logic        out_err_illegal;
  logic        out_err_incomplete;
  logic [3:0]  prof_h_set;
  logic [3:0]  prof_w_set;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calcore_decode_stage #(.NUM_PROFILES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_op             (out_op),
    .out_rd             (out_rd),
    .out_rs1            (out_rs1),
    .out_rs2            (out_rs2),
    .out_imm            (out_imm),
    .out_gender         (out_gender),
    .out_age            (out_age),
    .out_profile        (out_profile),
    .out_err_illegal    (out_err_illegal),
    .out_err_incomplete (out_err_incomplete),
    .prof_h_set         (prof_h_set),
    .prof_w_set         (prof_w_set)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle offer; with in_ready high and the FIFO drained the entry is
  // on the outputs right after the accepting edge.
  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    step();
    in_valid = 1'b0;
    in_instr = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_h_set", prof_h_set, 0);
    chk("rst_w_set", prof_w_set, 0);
    chk("rst_out_op", out_op, 0);

    out_ready = 1'b1;
    // SET_H p0, rd=1, imm=175
    send(32'h0AF0008B);
    chk("seth_valid", out_valid, 1);
    chk("seth_op", out_op, 1);
    chk("seth_imm", out_imm, 12'h0AF);
    chk("seth_rd", out_rd, 1);
    chk("seth_ill", out_err_illegal, 0);
    chk("seth_hflags", prof_h_set, 4'b0001);

    // BMI p0 before weight set
    send(32'h0000010D);
    chk("bmi1_op", out_op, 3);
    chk("bmi1_rd", out_rd, 2);
    chk("bmi1_inc", out_err_incomplete, 1);
    chk("bmi1_imm", out_imm, 0);

    // SET_W p0, imm=70
    send(32'h0460108B);
    chk("setw_op", out_op, 2);
    chk("setw_imm", out_imm, 12'h046);
    chk("setw_wflags", prof_w_set, 4'b0001);

    send(32'h0000010D);
    chk("bmi2_op", out_op, 3);
    chk("bmi2_inc", out_err_incomplete, 0);

    // BMR gender=1 age=30 rd=3
    send(32'hBC00018E);
    chk("bmr_op", out_op, 4);
    chk("bmr_gender", out_gender, 1);
    chk("bmr_age", out_age, 30);
    chk("bmr_rd", out_rd, 3);
    chk("bmr_imm", out_imm, 0);
    chk("bmr_ill", out_err_illegal, 0);
    chk("bmr_inc", out_err_incomplete, 0);

    // funct3=101 on SET opcode
    send(32'h0000508B);
    chk("f3_op", out_op, 7);
    chk("f3_ill", out_err_illegal, 1);
    chk("f3_imm", out_imm, 0);
    chk("f3_hflags", prof_h_set, 4'b0001);
    chk("f3_wflags", prof_w_set, 4'b0001);

    // SET_H with rs1=5: out of range
    send(32'h0AF2808B);
    chk("rs5_op", out_op, 1);
    chk("rs5_ill", out_err_illegal, 1);
    chk("rs5_rs1", out_rs1, 5);
    chk("rs5_prof", out_profile, 1);
    chk("rs5_hflags", prof_h_set, 4'b0001);

    // SET_W on profile 3
    send(32'h0461908B);
    chk("setw3_prof", out_profile, 3);
    chk("setw3_wflags", prof_w_set, 4'b1001);

    // BMR p3: weight only -> incomplete
    send(32'hBC01818E);
    chk("bmr3_inc", out_err_incomplete, 1);

    // All-zero -> NOP, unknown opcode -> ILLEGAL
    send(32'h00000000);
    chk("nop_valid", out_valid, 1);
    chk("nop_op", out_op, 0);
    chk("nop_ill", out_err_illegal, 0);
    send(32'h00A30033);
    chk("badopc_op", out_op, 7);
    chk("badopc_ill", out_err_illegal, 1);
    chk("badopc_rs2", out_rs2, 10);

    step();
    chk("drain_valid", out_valid, 0);

    // Backpressure: three back-to-back offers with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000010D;
    step();
    chk("bp1_in_ready", in_ready, 1);
    chk("bp1_valid", out_valid, 1);
    chk("bp1_op", out_op, 3);
    in_instr = 32'hBC00018E;
    step();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_op_stable", out_op, 3);
    chk("bp2_rd_stable", out_rd, 2);
    in_instr = 32'h0AF0008B;
    step();
    chk("bp3_in_ready", in_ready, 0);
    chk("bp3_op_stable", out_op, 3);
    out_ready = 1'b1;
    step();
    chk("ret1_op", out_op, 4);
    chk("ret1_in_ready", in_ready, 1);
    step();
    chk("ret2_op", out_op, 1);
    chk("ret2_imm", out_imm, 12'h0AF);
    in_valid = 1'b0;
    step();
    chk("ret_empty", out_valid, 0);

    // Flush with FIFO full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000010D;
    step();
    in_instr = 32'h0000010D;
    step();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_hflags", prof_h_set, 4'b0001);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_hflags", prof_h_set, 0);
    chk("fl_wflags", prof_w_set, 0);
    chk("fl_op", out_op, 0);

    // Flush beats a same-cycle handshake: SET_H must be dropped
    in_valid = 1'b1;
    in_instr = 32'h0AF0008B;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flhs_valid", out_valid, 0);
    chk("flhs_hflags", prof_h_set, 0);
    step();
    chk("flhs_valid2", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calcore_decode_stage.md
Name: calcore_decode_stage

Overview:
- Registered, parametrised successor to the CalCore combinational decoder.
- Accepts raw 32-bit CalCore instructions over a valid/ready handshake, decodes SET_HEIGHT, SET_WEIGHT, CALC_BMI and CALC_BMR, and buffers results in a 2-entry skid FIFO.
- Tracks per-profile "height set" and "weight set" flags.
- Flags illegal encodings, and calcs issued before the profile is fully set.
- Sits between instruction fetch and the BMI/BMR execute units.

Parameters:
- NUM_PROFILES, 4, number of user profiles tracked; must be 2..32 (power of two not required).
- PROF_W, $clog2(NUM_PROFILES), profile index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  clears FIFO and all profile flags next edge
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_op  out  3  op_t: NOP=0, SET_H=1, SET_W=2, BMI=3, BMR=4, ILLEGAL=7
- out_rd  out  5  instr[11:7]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_imm  out  12  instr[31:20] for SET_H/SET_W, else 0
- out_gender  out  1  instr[31] for BMR, else 0
- out_age  out  6  instr[30:25] for BMR, else 0
- out_profile  out  PROF_W  rs1[PROF_W-1:0]
- out_err_illegal  out  1  encoding or profile index invalid
- out_err_incomplete  out  1  calc issued with height or weight unset
- prof_h_set  out  NUM_PROFILES  height flag vector
- prof_w_set  out  NUM_PROFILES  weight flag vector

Behaviour:
- Reset / flush: FIFO count=0, pointers=0, out_valid=0, all decoded outputs=0, prof_h_set=prof_w_set=0, in_ready=1 in the following cycle. Flush has priority over a same-cycle handshake; the offered instruction is dropped.
- Decode:
  - opcode=instr[6:0].
  - 0001011 with funct3=000 -> SET_H; with funct3=001 -> SET_W; any other funct3 -> ILLEGAL.
  - 0001101 -> BMI.
  - 0001110 -> BMR.
  - All-zero instruction -> NOP.
  - Any other opcode -> ILLEGAL.
- Profile check: rs1 >= NUM_PROFILES on SET_H/SET_W/BMI/BMR -> op kept, out_err_illegal=1, no flag update.
- Scoreboard update on input handshake (in_valid & in_ready) only:
  - Legal SET_H sets prof_h_set[profile].
  - Legal SET_W sets prof_w_set[profile].
  - ILLEGAL entries update nothing.
- Incomplete check: BMI/BMR with !(h&w) for its profile -> err_incomplete=1. The check uses flags before this cycle's update; only one instruction arrives per cycle, so no hazard.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the FIFO was empty.
- FIFO:
  - in_ready = (count < 2), registered.
  - Push and pop in the same cycle with count=1 leaves count=1.
  - count=2 holds in_ready low; no push occurs.
- Output handshake: entry retires on out_valid & out_ready. Outputs are stable while out_valid & !out_ready.
- Flags stay set until rst or flush. A repeated SET overwrites nothing internally; the value travels downstream on out_imm.

Decomposition:
- calcore_pkg holds:
  - op_t enum.
  - Opcode constants: OPC_SET=7'b0001011, OPC_BMI=7'b0001101, OPC_BMR=7'b0001110.
  - FUNCT3_H=3'b000, FUNCT3_W=3'b001.
  - dec_entry_t packed struct of all out_* fields.
- Sub-module calcore_dec_comb: pure combinational decode, instr + flag vectors -> dec_entry_t.
- The top level owns the FIFO and scoreboard.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, flag vectors all 0.
- Send 0x0AF0008B (SET_H, rd=1, rs1=0, imm=175), out_ready=1 -> next cycle out_op=1, out_imm=0x0AF, out_rd=1; prof_h_set=4'b0001.
- Send 0x0000010D (BMI, rd=2, p0) before any SET_W -> out_op=3, out_err_incomplete=1. Then send 0x0460108B (SET_W, imm=70) and repeat the BMI -> err_incomplete=0.
- Send 0xBC00018E (BMR, gender=1, age=30, rd=3) with p0 complete -> out_op=4, out_gender=1, out_age=30, errors 0.
- Send 0x0000508B (funct3=101) -> out_op=7, err_illegal=1, flags unchanged. Send SET_H with rs1=5 -> err_illegal=1, prof_h_set unchanged.
- Hold out_ready=0 and push 3 back-to-back instructions -> in_ready drops after 2, third held. Raise out_ready -> retire in order. Assert flush with count=2 -> next cycle out_valid=0, flags cleared.
